// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO pull side plus valid/ready stream side of the read adapter.
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH     = 36,
   parameter int BUF_ADDR_WIDTH = 4
);
   logic                      fifo_empty;
   logic                      fifo_rd_en;
   logic [DATA_WIDTH-1:0]     fifo_rd_data;
   logic                      fifo_rd_valid;
   logic                      m_valid;
   logic                      m_ready;
   logic [DATA_WIDTH-1:0]     m_data;
   logic [BUF_ADDR_WIDTH:0]   buf_level;
   logic                      err_overflow;
   logic                      err_spurious;
   modport master (
      input  fifo_empty, fifo_rd_data, fifo_rd_valid, m_ready,
      output fifo_rd_en, m_valid, m_data, buf_level, err_overflow, err_spurious
   );
   modport slave (
      output fifo_empty, fifo_rd_data, fifo_rd_valid, m_ready,
      input  fifo_rd_en, m_valid, m_data, buf_level, err_overflow, err_spurious
   );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: credit-limited FIFO pull to valid/ready stream with a local skid buffer.
module fifo_rd_stream_adapter #(
   parameter int DATA_WIDTH     = 36,
   parameter int READ_LATENCY   = 11,
   parameter int BUF_ADDR_WIDTH = 4
) (
   input logic                 clk,
   input logic                 rst,
   fifo_rd_stream_if.master    bus
);
   localparam int A         = BUF_ADDR_WIDTH;
   localparam int W         = BUF_ADDR_WIDTH + 1;
   localparam int BUF_DEPTH = 1 << BUF_ADDR_WIDTH;
   if (BUF_DEPTH < READ_LATENCY + 2) begin : g_depth_check
      $error("BUF_DEPTH must be at least READ_LATENCY + 2");
   end
   logic [W-1:0]          inflight_q, inflight_d, credits_q, credits_d, occ_q, occ_d;
   logic [A-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
   logic                  ovf_q, ovf_d, spur_q, spur_d;
   logic                  rd_en, hs, full, wr;
   always_comb begin
      rd_en      = !bus.fifo_empty && (credits_q < W'(BUF_DEPTH));
      hs         = (occ_q != '0) && bus.m_ready;
      full       = occ_q == W'(BUF_DEPTH);
      wr         = bus.fifo_rd_valid && (!full || hs);
      // counters saturate at zero so spurious returns cannot wrap them
      inflight_d = inflight_q + W'(rd_en) - W'(bus.fifo_rd_valid && inflight_q != '0);
      credits_d  = credits_q + W'(rd_en) - W'(hs && credits_q != '0);
      occ_d      = occ_q + W'(wr) - W'(hs);
      wptr_d     = wptr_q + A'(wr);
      rptr_d     = rptr_q + A'(hs);
      for (int i = 0; i < BUF_DEPTH; i++)
         mem_d[i] = (wr && wptr_q == A'(i)) ? bus.fifo_rd_data : mem_q[i];
      ovf_d      = ovf_q || (bus.fifo_rd_valid && full && !hs);
      spur_d     = spur_q || (bus.fifo_rd_valid && inflight_q == '0);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= '0;
         credits_q  <= '0;
         occ_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         mem_q      <= '{default: '0};
         ovf_q      <= 1'b0;
         spur_q     <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         credits_q  <= credits_d;
         occ_q      <= occ_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         mem_q      <= mem_d;
         ovf_q      <= ovf_d;
         spur_q     <= spur_d;
      end
   end
   assign bus.fifo_rd_en   = rd_en;
   assign bus.m_valid      = occ_q != '0;
   assign bus.m_data       = mem_q[rptr_q];
   assign bus.buf_level    = occ_q;
   assign bus.err_overflow = ovf_q;
   assign bus.err_spurious = spur_q;
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: FIFO read-latency model, scoreboard, table-driven random phases and corner sequences.
module tb_fifo_rd_stream_adapter;
   localparam int DW = 36, RL = 11, AW = 4, DEPTH = 16;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   fifo_rd_stream_if #(.DATA_WIDTH(DW), .BUF_ADDR_WIDTH(AW)) bus ();
   fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .READ_LATENCY(RL), .BUF_ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   typedef struct {
      int n_beats;
      int ready_pct;
      bit toggle_empty;
      bit exp_ovf;
      bit exp_spur;
      int exp_level;
   } vec_t;
   vec_t vecs [4];
   logic [DW-1:0] src_q [$];
   logic [DW-1:0] exp_q [$];
   bit            pv [RL];
   logic [DW-1:0] pd [RL];
   int  n_vec, n_err, cyc, rd_en_cnt, hs_cnt, max_level, ready_pct, first_en, first_v, bubbles, g, cnt;
   bit  hold_empty, toggle_empty, inj, count_bub;
   logic [DW-1:0] inj_d;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load(input int n, input int base);
      for (int i = 0; i < n; i++) src_q.push_back(DW'(base + i));
   endtask

   task automatic tick();
      bit cap_en;
      logic [DW-1:0] cap_d;
      @(negedge clk);
      cap_en = bus.fifo_rd_en;
      cap_d  = '0;
      if (cap_en) begin
         rd_en_cnt++;
         if (first_en < 0) first_en = cyc;
         if (src_q.size() == 0) chk("rd_en_while_empty", 64'd1, 64'd0);
         else begin
            cap_d = src_q.pop_front();
            exp_q.push_back(cap_d);
         end
      end
      if (bus.m_valid && first_v < 0) first_v = cyc;
      if (count_bub && first_v >= 0 && !bus.m_valid) bubbles++;
      if (bus.m_valid && bus.m_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) chk("unexpected_beat", 64'(bus.m_data), 64'hffff_ffff_ffff_ffff);
         else chk("m_data", 64'(bus.m_data), 64'(exp_q.pop_front()));
      end
      if (int'(bus.buf_level) > max_level) max_level = int'(bus.buf_level);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = RL - 1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pd[i] = pd[i-1];
      end
      pv[0] = cap_en;
      pd[0] = cap_d;
      bus.fifo_rd_valid = pv[RL-1] | inj;
      bus.fifo_rd_data  = inj ? inj_d : pd[RL-1];
      inj = 1'b0;
      if (toggle_empty) hold_empty = 1'($urandom_range(0, 1));
      bus.m_ready    = int'($urandom_range(0, 99)) < ready_pct;
      bus.fifo_empty = hold_empty || src_q.size() == 0;
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; rd_en_cnt = 0; hs_cnt = 0; max_level = 0;
      first_en = -1; first_v = -1; bubbles = 0; count_bub = 1'b0;
      hold_empty = 1'b1; toggle_empty = 1'b0; inj = 1'b0; inj_d = '0; ready_pct = 0;
      for (int i = 0; i < RL; i++) begin pv[i] = 1'b0; pd[i] = '0; end
      vecs[0] = '{50, 30, 1'b1, 1'b0, 1'b0, 0};
      vecs[1] = '{50, 70, 1'b0, 1'b0, 1'b0, 0};
      vecs[2] = '{30, 100, 1'b1, 1'b0, 1'b0, 0};
      vecs[3] = '{40, 10, 1'b1, 1'b0, 1'b0, 0};
      rst = 1'b1;
      bus.fifo_empty = 1'b1; bus.fifo_rd_valid = 1'b0; bus.fifo_rd_data = '0; bus.m_ready = 1'b0;
      repeat (3) tick();
      chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
      chk("rst_m_data", 64'(bus.m_data), 64'd0);
      chk("rst_buf_level", 64'(bus.buf_level), 64'd0);
      chk("rst_err_overflow", 64'(bus.err_overflow), 64'd0);
      chk("rst_err_spurious", 64'(bus.err_spurious), 64'd0);
      chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      // streaming: 100 beats, ready always high
      load(100, 0);
      hold_empty = 1'b0;
      bus.fifo_empty = 1'b0;
      #1 chk("rst_rd_en_follows_empty", 64'(bus.fifo_rd_en), 64'd1);
      rst = 1'b0;
      #1 chk("rd_en_first_cycle", 64'(bus.fifo_rd_en), 64'd1);
      ready_pct = 100; bus.m_ready = 1'b1;
      hs_cnt = 0; first_en = -1; first_v = -1; bubbles = 0; count_bub = 1'b1; cyc = 0;
      while (hs_cnt < 100 && cyc < 400) tick();
      count_bub = 1'b0;
      chk("stream_beats", 64'(hs_cnt), 64'd100);
      chk("stream_latency", 64'(first_v - first_en), 64'd12);
      chk("stream_bubbles", 64'(bubbles), 64'd0);
      chk("stream_drained", 64'(exp_q.size()), 64'd0);
      // backpressure: 40 queued, consumer stalled
      ready_pct = 0; rd_en_cnt = 0; max_level = 0;
      load(40, 1000);
      repeat (60) tick();
      chk("bp_rd_en_pulses", 64'(rd_en_cnt), 64'd16);
      chk("bp_buf_level", 64'(bus.buf_level), 64'(DEPTH));
      chk("bp_rd_en_low", 64'(bus.fifo_rd_en), 64'd0);
      chk("bp_err_overflow", 64'(bus.err_overflow), 64'd0);
      ready_pct = 100; hs_cnt = 0; g = 0;
      while (hs_cnt < 40 && g < 500) begin tick(); g++; end
      chk("bp_beats_out", 64'(hs_cnt), 64'd40);
      repeat (2) tick();
      chk("bp_level_end", 64'(bus.buf_level), 64'd0);
      // random phases from the table
      for (int v = 0; v < 4; v++) begin
         ready_pct = vecs[v].ready_pct;
         toggle_empty = vecs[v].toggle_empty;
         max_level = 0;
         load(vecs[v].n_beats, 2000 + 100 * v);
         g = 0;
         while ((src_q.size() != 0 || exp_q.size() != 0) && g < 5000) begin tick(); g++; end
         toggle_empty = 1'b0; hold_empty = 1'b0;
         repeat (2) tick();
         chk("tbl_drained", 64'(src_q.size() + exp_q.size()), 64'd0);
         chk("tbl_max_level_ok", 64'(max_level <= DEPTH), 64'd1);
         chk("tbl_err_overflow", 64'(bus.err_overflow), 64'(vecs[v].exp_ovf));
         chk("tbl_err_spurious", 64'(bus.err_spurious), 64'(vecs[v].exp_spur));
         chk("tbl_level_end", 64'(bus.buf_level), 64'(vecs[v].exp_level));
      end
      // spurious return with nothing in flight: stored anyway
      ready_pct = 0; hold_empty = 1'b1;
      tick();
      inj = 1'b1; inj_d = DW'(36'h5A5A);
      exp_q.push_back(inj_d);
      tick();
      tick();
      chk("spur_flag", 64'(bus.err_spurious), 64'd1);
      chk("spur_stored", 64'(bus.buf_level), 64'd1);
      ready_pct = 100;
      repeat (5) tick();
      chk("spur_sticky", 64'(bus.err_spurious), 64'd1);
      chk("spur_drained", 64'(exp_q.size()), 64'd0);
      // overflow: fill buffer, force one extra return
      ready_pct = 0; hold_empty = 1'b0;
      load(16, 3000);
      repeat (40) tick();
      chk("ovf_full", 64'(bus.buf_level), 64'(DEPTH));
      inj = 1'b1; inj_d = DW'(36'hBAD);
      tick();
      tick();
      chk("ovf_flag", 64'(bus.err_overflow), 64'd1);
      chk("ovf_level_held", 64'(bus.buf_level), 64'(DEPTH));
      ready_pct = 100; g = 0;
      while (exp_q.size() != 0 && g < 200) begin tick(); g++; end
      repeat (3) tick();
      chk("ovf_drained", 64'(exp_q.size()), 64'd0);
      chk("ovf_discarded", 64'(bus.buf_level), 64'd0);
      // mid-stream reset with 5 in flight and 3 buffered
      rst = 1'b1;
      #1 rst = 1'b0;
      chk("rst_clears_ovf", 64'(bus.err_overflow), 64'd0);
      chk("rst_clears_spur", 64'(bus.err_spurious), 64'd0);
      ready_pct = 0; hold_empty = 1'b0;
      load(8, 4000);
      g = 0;
      while (bus.buf_level != 3 && g < 100) begin tick(); g++; end
      cnt = 0;
      for (int i = 0; i < RL; i++) cnt += int'(pv[i]);
      chk("mid_inflight", 64'(cnt), 64'd5);
      chk("mid_level_before", 64'(bus.buf_level), 64'd3);
      rst = 1'b1;
      hold_empty = 1'b1; bus.fifo_empty = 1'b1;
      #1;
      chk("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
      chk("mid_rst_level", 64'(bus.buf_level), 64'd0);
      rst = 1'b0;
      exp_q.delete();
      repeat (10) tick();
      chk("late_err_spurious", 64'(bus.err_spurious), 64'd1);
      chk("late_level", 64'(bus.buf_level), 64'd5);
      chk("late_err_overflow", 64'(bus.err_overflow), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
